// File: rtl/bitstream_pkg.sv
// Shared widths, types and helpers for the bitstream reader slice.
// Optional feature macro used by this slice: BITREADER_ALIGN_EN (byte-align skip).
package bitstream_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned BUF_W       = 32;
    localparam int unsigned MAX_CONSUME = 16;

    typedef logic [5:0] fill_t;
    typedef logic [4:0] consume_t;

    // Bits to skip to reach the next byte boundary: (8 - pos) mod 8.
    function automatic consume_t alignSkip(input logic [2:0] posLow);
        return consume_t'(3'(~posLow + 3'd1));
    endfunction

endpackage

// File: rtl/bitstream_reader_if.sv
// Bundle of the FIFO consume side and the decoder-facing window signals.
//   master: the reader (pops FIFO, presents Window/BitsAvail/BitPos/ConsumeErr)
//   slave : the FIFO plus syntax decoder around it
// Align exists only when BITREADER_ALIGN_EN is defined.
interface bitstream_reader_if
    import bitstream_pkg::*;
#(
    parameter int unsigned POS_W = 24
);
    logic [WORD_W-1:0] FifoData;
    logic              FifoEmpty;
    logic              FifoRead;
    logic              ConsumeValid;
    consume_t          Consume;
`ifdef BITREADER_ALIGN_EN
    logic              Align;
`endif
    logic [WORD_W-1:0] Window;
    logic              WindowValid;
    fill_t             BitsAvail;
    logic [POS_W-1:0]  BitPos;
    logic              ConsumeErr;

`ifdef BITREADER_ALIGN_EN
    modport master (
        input  FifoData, FifoEmpty, ConsumeValid, Consume, Align,
        output FifoRead, Window, WindowValid, BitsAvail, BitPos, ConsumeErr
    );
    modport slave (
        output FifoData, FifoEmpty, ConsumeValid, Consume, Align,
        input  FifoRead, Window, WindowValid, BitsAvail, BitPos, ConsumeErr
    );
`else
    modport master (
        input  FifoData, FifoEmpty, ConsumeValid, Consume,
        output FifoRead, Window, WindowValid, BitsAvail, BitPos, ConsumeErr
    );
    modport slave (
        output FifoData, FifoEmpty, ConsumeValid, Consume,
        input  FifoRead, Window, WindowValid, BitsAvail, BitPos, ConsumeErr
    );
`endif

endinterface

// File: rtl/bs_funnel_shift.sv
// Combinational funnel: drops the consumed bits from the top of the buffer and
// lands an optional refill word directly behind the surviving bits.
//   bufIn/fillIn   current buffer and bit count
//   take           bits consumed this cycle (already legality-checked)
//   word/load      FIFO head word and whether it is popped this cycle
//   bufOut/fillOut next buffer and bit count
module bs_funnel_shift
    import bitstream_pkg::*;
(
    input  logic [BUF_W-1:0]  bufIn,
    input  fill_t             fillIn,
    input  consume_t          take,
    input  logic [WORD_W-1:0] word,
    input  logic              load,
    output logic [BUF_W-1:0]  bufOut,
    output fill_t             fillOut
);

    fill_t            survive;
    logic [BUF_W-1:0] kept;
    logic [BUF_W-1:0] landed;

    // Load only happens with fillIn <= 16, so survive <= 16 and the word fits.
    always_comb begin
        survive = fillIn - fill_t'(take);
        kept    = bufIn << take;
        landed  = '0;
        if (load) begin
            landed = {word, {(BUF_W - WORD_W){1'b0}}} >> survive;
        end
        bufOut  = kept | landed;
        fillOut = survive + (load ? fill_t'(WORD_W) : fill_t'(0));
    end

endmodule

// File: rtl/bitstream_reader.sv
// Bit-level reader on the consume side of the 16-bit bitstream FIFO.
// Keeps a 32-bit left-aligned buffer, shows the next 16 bits MSB-first and
// tracks the absolute consumed-bit position.
//   Clk, Reset (sync, active-high), Enable (low clears like Reset)
//   bus (master): FifoData/FifoEmpty/FifoRead, ConsumeValid/Consume[/Align],
//                 Window, WindowValid, BitsAvail, BitPos, ConsumeErr
// Macro BITREADER_ALIGN_EN adds the Align byte-boundary skip.
module bitstream_reader
    import bitstream_pkg::*;
#(
    parameter int unsigned POS_W = 24
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    bitstream_reader_if.master bus
);

    logic [BUF_W-1:0] bufState;
    logic [BUF_W-1:0] bufNext;
    fill_t            fill;
    fill_t            fillNext;
    logic [POS_W-1:0] bitPos;
    logic             consumeErr;
    consume_t         take;
    logic             reqErr;
    logic             load;

    // Refill decision uses registered fill only; no path from Consume.
    assign load = Enable & ~Reset & ~bus.FifoEmpty & (fill <= fill_t'(WORD_W));

    // Request legality and effective consume count.
    always_comb begin
        take   = '0;
        reqErr = 1'b0;
        if (bus.ConsumeValid) begin
            reqErr = (bus.Consume > consume_t'(MAX_CONSUME)) ||
                     (fill_t'(bus.Consume) > fill);
`ifdef BITREADER_ALIGN_EN
            if (bus.Align) begin
                reqErr = 1'b1;
            end
`endif
            if (!reqErr) begin
                take = bus.Consume;
            end
        end
`ifdef BITREADER_ALIGN_EN
        else if (bus.Align) begin
            if (fill_t'(alignSkip(bitPos[2:0])) > fill) begin
                reqErr = 1'b1;
            end else begin
                take = alignSkip(bitPos[2:0]);
            end
        end
`endif
    end

    bs_funnel_shift funnel (
        .bufIn   (bufState),
        .fillIn  (fill),
        .take    (take),
        .word    (bus.FifoData),
        .load    (load),
        .bufOut  (bufNext),
        .fillOut (fillNext)
    );

    // State registers; Enable low behaves exactly like Reset.
    always_ff @(posedge Clk) begin
        if (Reset || !Enable) begin
            bufState   <= '0;
            fill       <= '0;
            bitPos     <= '0;
            consumeErr <= 1'b0;
        end else begin
            bufState   <= bufNext;
            fill       <= fillNext;
            bitPos     <= bitPos + POS_W'(take);
            consumeErr <= reqErr;
        end
    end

    assign bus.FifoRead    = load;
    assign bus.Window      = bufState[BUF_W-1 -: WORD_W];
    assign bus.WindowValid = (fill >= fill_t'(WORD_W));
    assign bus.BitsAvail   = fill;
    assign bus.BitPos      = bitPos;
    assign bus.ConsumeErr  = consumeErr;

endmodule

// File: tb/tb_bitstream_reader.sv
// Scoreboard bench for bitstream_reader: the driver pushes the expected
// post-edge state for each cycle, a monitor pops and compares after the edge.
// Cycle schedule (P = posedge): P+1 FIFO pop/refresh, P+2 monitor,
// P+3 driver, P+4 FIFO refresh, P+5 FIFO samples FifoRead.
module tb_bitstream_reader;
    import bitstream_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] window;
        logic        valid;
        logic [5:0]  avail;
        logic [23:0] pos;
        logic        err;
        logic        rd;
        logic [5:0]  chk;   // 0 window,1 valid,2 avail,3 pos,4 err,5 FifoRead
    } exp_t;

    localparam logic [5:0] C5 = 6'b011111;
    localparam logic [5:0] C6 = 6'b111111;

    logic Clk;
    logic Reset;
    logic Enable;
    int   total;
    int   bad;
    exp_t expQ[$];
    logic [15:0] fifoQ[$];
    logic popReq;
`ifdef BITREADER_ALIGN_EN
    logic alignNext;
`endif

    bitstream_reader_if #(.POS_W(24)) bus ();

    bitstream_reader #(.POS_W(24)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (Enable),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t mk(input string n, input logic [15:0] w, input logic v,
                                input logic [5:0] a, input logic [23:0] p,
                                input logic er, input logic rd, input logic [5:0] chk);
        exp_t e;
        e.name = n; e.window = w; e.valid = v; e.avail = a;
        e.pos = p; e.err = er; e.rd = rd; e.chk = chk;
        return e;
    endfunction

    function automatic logic [15:0] wordOf(input int k);
        return 16'(k * 291 + 241);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic rst, input logic en, input logic cv,
                        input logic [4:0] cons, input exp_t e);
        @(posedge Clk);
        #3;
        Reset            = rst;
        Enable           = en;
        bus.ConsumeValid = cv;
        bus.Consume      = cons;
`ifdef BITREADER_ALIGN_EN
        bus.Align        = alignNext;
`endif
        expQ.push_back(e);
    endtask

    // FIFO model: first-word-fall-through head, popped after the edge that read it.
    initial begin
        popReq        = 1'b0;
        bus.FifoData  = '0;
        bus.FifoEmpty = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            if (popReq && fifoQ.size() > 0) void'(fifoQ.pop_front());
            bus.FifoEmpty = (fifoQ.size() == 0);
            bus.FifoData  = (fifoQ.size() > 0) ? fifoQ[0] : 16'h0;
            #3;
            bus.FifoEmpty = (fifoQ.size() == 0);
            bus.FifoData  = (fifoQ.size() > 0) ? fifoQ[0] : 16'h0;
            #1;
            popReq = bus.FifoRead;
        end
    end

    // Monitor: compare the registered outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (e.chk[0]) check({e.name, ".Window"},      32'(bus.Window),      32'(e.window));
                if (e.chk[1]) check({e.name, ".WindowValid"}, 32'(bus.WindowValid), 32'(e.valid));
                if (e.chk[2]) check({e.name, ".BitsAvail"},   32'(bus.BitsAvail),   32'(e.avail));
                if (e.chk[3]) check({e.name, ".BitPos"},      32'(bus.BitPos),      32'(e.pos));
                if (e.chk[4]) check({e.name, ".ConsumeErr"},  32'(bus.ConsumeErr),  32'(e.err));
                if (e.chk[5]) check({e.name, ".FifoRead"},    32'(bus.FifoRead),    32'(e.rd));
            end
        end
    end

    initial begin
        total            = 0;
        bad              = 0;
        Reset            = 1'b1;
        Enable           = 1'b0;
        bus.ConsumeValid = 1'b0;
        bus.Consume      = '0;
`ifdef BITREADER_ALIGN_EN
        alignNext        = 1'b0;
        bus.Align        = 1'b0;
`endif

        // Basic fill, consume, overlong and underrun requests.
        step(1, 0, 0, 0,  mk("rst",      16'h0000, 0, 0,  0,  0, 0, C6));
        fifoQ.push_back(16'hA5C3);
        fifoQ.push_back(16'h1234);
        step(0, 1, 0, 0,  mk("fill16",   16'hA5C3, 1, 16, 0,  0, 0, C5));
        step(0, 1, 0, 0,  mk("fill32",   16'hA5C3, 1, 32, 0,  0, 0, C6));
        step(0, 1, 1, 4,  mk("cons4",    16'h5C31, 1, 28, 4,  0, 0, C6));
        fifoQ.push_back(16'hBEEF);
        step(0, 1, 1, 12, mk("cons12",   16'h1234, 1, 16, 16, 0, 1, C6));
        step(0, 1, 0, 0,  mk("refill",   16'h1234, 1, 32, 16, 0, 0, C6));
        step(0, 1, 1, 17, mk("over16",   16'h1234, 1, 32, 16, 1, 0, C6));
        step(0, 1, 0, 0,  mk("errclr",   16'h1234, 1, 32, 16, 0, 0, C6));
        step(0, 1, 1, 16, mk("drain16",  16'hBEEF, 1, 16, 32, 0, 0, C6));
        step(0, 1, 1, 16, mk("drain0",   16'h0000, 0, 0,  48, 0, 0, C6));
        step(0, 1, 1, 1,  mk("underrun", 16'h0000, 0, 0,  48, 1, 0, C6));
        step(0, 1, 1, 0,  mk("zero",     16'h0000, 0, 0,  48, 0, 0, C6));

        // Enable dropped mid-stream with Fill=24, BitPos=40.
        step(1, 1, 0, 0,  mk("rst2",     16'h0000, 0, 0,  0,  0, 0, C6));
        fifoQ.delete();
        fifoQ.push_back(16'h1111);
        fifoQ.push_back(16'h2222);
        fifoQ.push_back(16'h3333);
        fifoQ.push_back(16'h4444);
        fifoQ.push_back(16'h5555);
        step(0, 1, 0, 0,  mk("e_fill",   16'h1111, 1, 16, 0,  0, 1, C6));
        step(0, 1, 1, 8,  mk("e_c8a",    16'h1122, 1, 24, 8,  0, 0, C6));
        step(0, 1, 1, 16, mk("e_c16",    16'h2200, 0, 8,  24, 0, 1, C6));
        step(0, 1, 1, 8,  mk("e_c8b",    16'h3333, 1, 16, 32, 0, 1, C6));
        step(0, 1, 1, 8,  mk("e_c8c",    16'h3344, 1, 24, 40, 0, 0, C6));
        step(0, 0, 1, 4,  mk("e_off",    16'h0000, 0, 0,  0,  0, 0, C6));
        step(0, 1, 0, 0,  mk("e_on",     16'h5555, 1, 16, 0,  0, 0, C6));
        step(0, 1, 1, 0,  mk("e_zero",   16'h5555, 1, 16, 0,  0, 0, C6));

        // Sustained 16 bits per cycle from a FIFO that never empties.
        step(1, 1, 0, 0,  mk("rst3",     16'h0000, 0, 0,  0,  0, 0, C6));
        fifoQ.delete();
        for (int k = 0; k < 104; k++) fifoQ.push_back(wordOf(k));
        step(0, 1, 0, 0,  mk("t_warm",   wordOf(0), 1, 16, 0, 0, 1, C6));
        for (int i = 1; i <= 100; i++) begin
            step(0, 1, 1, 16, mk("t_run", wordOf(i), 1, 16, 24'(16 * i), 0, 1, C6));
        end

`ifdef BITREADER_ALIGN_EN
        // Byte alignment skip, repeat at a boundary, and Align with ConsumeValid.
        step(1, 1, 0, 0,  mk("rst4",     16'h0000, 0, 0,  0,  0, 0, C6));
        fifoQ.delete();
        fifoQ.push_back(16'hAAAA);
        step(0, 1, 0, 0,  mk("a_fill",   16'hAAAA, 1, 16, 0,  0, 0, C6));
        step(0, 1, 1, 3,  mk("a_c3",     16'h5550, 0, 13, 3,  0, 0, C6));
        alignNext = 1'b1;
        step(0, 1, 0, 0,  mk("a_align",  16'hAA00, 0, 8,  8,  0, 0, C6));
        step(0, 1, 0, 0,  mk("a_again",  16'hAA00, 0, 8,  8,  0, 0, C6));
        step(0, 1, 1, 4,  mk("a_both",   16'hAA00, 0, 8,  8,  1, 0, C6));
        alignNext = 1'b0;
        step(0, 1, 0, 0,  mk("a_idle",   16'hAA00, 0, 8,  8,  0, 0, C6));
`endif

        @(posedge Clk);
        @(posedge Clk);
        #5;
        check("drain.expQ", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitstream_reader.md
# bitstream_reader

Bit-level reader on the consume side of the 16-bit coefficient/bitstream FIFO. It pulls whole 16-bit words from the FIFO head and keeps them in a 32-bit left-aligned shift buffer. It presents the next 16 unconsumed bits, MSB-first, to the CAVLC syntax decoder, which consumes 0..16 bits per cycle. It also tracks an absolute bit position for slice and byte bookkeeping.

## Interface
- POS_W, 24: width of the absolute bit-position counter.
- Clk  in  1  clock, all logic on rising edge.
- Reset  in  1  reset, synchronous and active-high.
- Enable  in  1  synchronous enable. When low, all state clears on the next edge, same as Reset.
- FifoData  in  16  FIFO head word. Valid whenever FifoEmpty is low (first-word-fall-through).
- FifoEmpty  in  1  FIFO empty flag.
- FifoRead  out  1  pops the FIFO head this cycle.
- ConsumeValid  in  1  decoder consumes Consume bits this cycle.
- Consume  in  5  bit count, legal range 0..16.
- Align  in  1  discard bits up to the next byte boundary. Present only under BITREADER_ALIGN_EN.
- Window  out  16  next 16 unconsumed bits. Bit 15 is the oldest. Zero-padded past BitsAvail.
- WindowValid  out  1  BitsAvail >= 16.
- BitsAvail  out  6  buffered bits, 0..32.
- BitPos  out  POS_W  total bits consumed since reset or Enable low, modulo 2^POS_W.
- ConsumeErr  out  1  one-cycle error pulse.

## Operation
- State: Buf[31:0], Fill[5:0], BitPos, ConsumeErr.
- Invariant: Buf bits below position 32-Fill are always zero.
- Outputs derived from state:
  - Window = Buf[31:16]
  - BitsAvail = Fill
  - WindowValid = Fill >= 16
- Effective consume c:
  - Consume when ConsumeValid=1 and the request is legal.
  - Otherwise c = 0.
- An illegal request sets ConsumeErr=1 for the next cycle and leaves Buf, Fill and BitPos unchanged by consume. A request is illegal when any of these holds:
  - Consume > 16
  - Consume > Fill
  - Align and ConsumeValid are asserted together
- Refill: FifoRead = Enable & ~Reset & ~FifoEmpty & (Fill <= 16). It depends on registered Fill only and has no combinational path from Consume.
- Next-state update, computed in this order:
  - Buf' = (Buf << c) | (FifoRead ? FifoData << (16 - (Fill - c)) : 0), in 32 bits.
  - Fill' = Fill - c + (FifoRead ? 16 : 0). This never exceeds 32.
  - BitPos' = BitPos + c, wrapping modulo 2^POS_W.
- Consume and refill in the same cycle are both applied. The refill word lands directly behind the surviving bits.
- Consume of 0 with ConsumeValid=1 is legal and a no-op.
- Reset or Enable low:
  - Buf, Fill, BitPos and ConsumeErr become 0.
  - FifoRead is 0 during that cycle.
  - In-flight ConsumeValid is ignored.

## Timing
- Reset values:
  - Window = 0, WindowValid = 0, BitsAvail = 0, BitPos = 0, ConsumeErr = 0.
  - FifoRead = 0 while Reset is high.
- FIFO word to Window: 1 cycle. A word popped at edge N is visible after edge N.
- Consume to updated Window, BitsAvail and BitPos: 1 cycle, all registered.
- Throughput: a FIFO that never empties sustains 16 bits per cycle. Starting at Fill = 16, each consume of 16 plus the refill returns Fill to 16.
- Startup with a non-empty FIFO:
  - WindowValid rises 1 cycle after Enable.
  - Fill reaches 32 after 2 cycles.
- ConsumeErr is high for exactly the cycle after the offending request.

## Configuration
- BITREADER_ALIGN_EN defined:
  - The Align input exists.
  - When Align=1 and ConsumeValid=0, c = (8 - BitPos[2:0]) mod 8.
  - If that c > Fill, the request is illegal, raises ConsumeErr, and does not consume.
  - Align at a byte boundary is a legal no-op.
- BITREADER_ALIGN_EN undefined:
  - The Align port and its logic are absent.
  - Only ConsumeValid moves bits.

## Structure
- Package bitstream_pkg holds:
  - WORD_W=16, BUF_W=32, MAX_CONSUME=16.
  - typedef fill_t (logic [5:0]).
  - typedef consume_t (logic [4:0]).
- One sub-module, bs_funnel_shift, is purely combinational. It takes Buf, Fill, c, FifoData and the load flag, and produces Buf' and Fill'.
- The top level holds the registers, FifoRead, error detection, BitPos and alignment.

## Test plan
- Reset, FIFO supplies 0xA5C3 then 0x1234, no consume -> Fill reaches 16 then 32, Window=0xA5C3. Then consume 4 -> Window=0x5C31, BitsAvail=28, BitPos=4.
- Fill=32, ConsumeValid with Consume=17 -> ConsumeErr pulses 1 cycle; Window, BitsAvail and BitPos unchanged.
- FIFO empty, Fill=16, consume 16 then consume 1 -> first: BitsAvail=0, WindowValid=0; second: ConsumeErr=1, BitPos=16.
- FIFO never empty, consume 16 every cycle for 100 cycles after warmup -> FifoRead=1 every cycle, WindowValid stays 1, BitPos=1600 mod 2^24, Window tracks the words in order.
- BITREADER_ALIGN_EN: BitPos=3, Fill=20, Align=1 -> BitPos=8, BitsAvail=15. Align again -> no change, no error.
- Enable dropped mid-stream with Fill=24 and BitPos=40 -> next cycle all outputs 0. Re-enable -> restarts from the current FIFO head with BitPos=0.
